td4_prog_mem: RTL and testbench
===============================

TD4_PROG_MEM -- requirements
Module: td4_prog_mem

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high, named clk and clr.
REQ-002 The block SHALL have parameter RELEASE_CYCLES, default 3: number of cycles the CPU is held in reset after a load or after reset (legal range 1..15).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 clr  input  1  synchronous active-high reset.
REQ-005 addr_rom  input  4  CPU fetch address.
REQ-006 data_rom  output  8  instruction byte returned to the CPU.
REQ-007 ld_start  input  1  request to begin a program load.
REQ-008 ld_len  input  4  index of the last word to load, sampled with ld_start.
REQ-009 ld_valid  input  1  ld_data is valid this cycle.
REQ-010 ld_data  input  8  program byte to write.
REQ-011 ld_ready  output  1  block accepts ld_data this cycle.
REQ-012 ld_busy  output  1  high whenever the state is not RUN.
REQ-013 ld_done  output  1  one-cycle pulse when a load completes and the CPU is released.
REQ-014 ld_sum  output  8  modulo-256 sum of bytes accepted in the current or last load.
REQ-015 cpu_clr_n  output  1  active-low reset to the CPU core; registered.

Function
REQ-016 Storage SHALL be 16 words x 8 bits, written only in LOAD.
REQ-017 In RUN, data_rom SHALL equal mem[addr_rom] combinationally, with no cycle latency; in LOAD and RELEASE, data_rom SHALL be 8'h00.
REQ-018 The FSM SHALL have states RUN, LOAD and RELEASE.
REQ-019 RUN: ld_ready=0 and cpu_clr_n=1; ld_start=1 at a clock edge SHALL move to LOAD, set wr_ptr=0, latch last=ld_len and clear ld_sum.
REQ-020 LOAD: ld_ready=1 and cpu_clr_n=0; at each edge with ld_valid=1, the block SHALL write mem[wr_ptr]=ld_data and update ld_sum+=ld_data (mod 256).
REQ-021 In LOAD, if wr_ptr==last at the accepting edge, the block SHALL enter RELEASE; otherwise wr_ptr SHALL increment.
REQ-022 wr_ptr SHALL never wrap; ld_len=15 loads all 16 words and ld_len=0 loads one word.
REQ-023 A cycle with ld_valid=0 in LOAD SHALL leave wr_ptr, memory and ld_sum unchanged; there is no timeout.
REQ-024 RELEASE: ld_ready=0 and cpu_clr_n=0 for exactly RELEASE_CYCLES cycles, then the FSM SHALL move to RUN.
REQ-025 ld_done SHALL be high for the first RUN cycle only when RELEASE was entered from LOAD.
REQ-026 ld_start SHALL be ignored in LOAD and RELEASE; ld_valid SHALL be ignored in RUN and RELEASE.
REQ-027 ld_sum SHALL hold its value after a load until the next accepted ld_start or reset.
REQ-028 ld_busy SHALL be 1 in LOAD and RELEASE, 0 in RUN.

Reset
REQ-029 While clr=1, the block SHALL clear all 16 words to 8'h00, set wr_ptr=0, ld_sum=0, ld_done=0 and cpu_clr_n=0, and enter RELEASE with its counter at RELEASE_CYCLES and a "from load" flag of 0.
REQ-030 After clr falls, cpu_clr_n SHALL stay 0 for RELEASE_CYCLES cycles and then go to 1 with no ld_done pulse.
REQ-031 clr asserted during LOAD SHALL abort the load, discarding partial contents, since memory is cleared.

Verification
REQ-032 Reset: clr=1 for 2 cycles, then clr=0 -> cpu_clr_n=0 and ld_busy=1 for 3 cycles, then cpu_clr_n=1 and ld_busy=0; data_rom=8'h00 for addr 0..15; ld_done stays 0.
REQ-033 Basic load: ld_start with ld_len=3, then bytes 0x20,0x02,0x40,0x90 on 4 consecutive valid cycles -> ld_ready=1 for 4 cycles, then 3 RELEASE cycles, then ld_done pulses once; ld_sum=0xF2; data_rom for addr 0..4 = 0x20,0x02,0x40,0x90,0x00.
REQ-034 Bubbles: same load with ld_valid low on alternate cycles -> identical memory contents and ld_sum=0xF2; the LOAD phase lasts 7 cycles.
REQ-035 Full depth: ld_len=15 with 16 bytes of 0xFF -> all 16 addresses read 0xFF, ld_sum=0xF0, and exactly 16 writes occur with no wrap.
REQ-036 Abort: clr=1 after 2 of 4 bytes -> all words read 0x00, ld_sum=0x00, no ld_done, and the normal post-reset release sequence follows.
REQ-037 Ignored start: ld_start pulses during LOAD and RELEASE -> no restart; wr_ptr, last and ld_sum are unaffected; exactly one ld_done pulse occurs.

Source files
------------

// File: rtl/td4_prog_mem_if.sv
// Bus bundle for the TD4 program memory: CPU fetch port, loader handshake and status.
// The master side is the loader/CPU environment; the memory block is the slave.
interface td4_prog_mem_if;
    logic [3:0] addr_rom;
    logic [7:0] data_rom;
    logic       cpu_clr_n;
    logic       ld_start;
    logic [3:0] ld_len;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_ready;
    logic       ld_busy;
    logic       ld_done;
    logic [7:0] ld_sum;

    modport master (
        output addr_rom, ld_start, ld_len, ld_valid, ld_data,
        input  data_rom, cpu_clr_n, ld_ready, ld_busy, ld_done, ld_sum
    );

    modport slave (
        input  addr_rom, ld_start, ld_len, ld_valid, ld_data,
        output data_rom, cpu_clr_n, ld_ready, ld_busy, ld_done, ld_sum
    );
endinterface

// File: rtl/td4_prog_mem.sv
// 16x8 TD4 program memory with a streaming loader; holds the CPU in reset while
// loading and for RELEASE_CYCLES cycles afterwards.
module td4_prog_mem #(
    parameter int RELEASE_CYCLES = 3
) (
    input  logic                clk,
    input  logic                clr,
    td4_prog_mem_if.slave       bus
);
    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_REL  = 2'd2;
    localparam logic [3:0] REL_INIT = 4'(RELEASE_CYCLES);

    logic [1:0] r_state;
    logic [3:0] r_wr_ptr;
    logic [3:0] r_last;
    logic [3:0] r_cnt;
    logic [7:0] r_sum;
    logic       r_from_load;
    logic       r_done;
    logic       r_cpu_clr_n;
    logic [7:0] r_mem [16];
    logic       w_accept;

    assign w_accept = (r_state == S_LOAD) && bus.ld_valid;

    // Reset wipes the whole array so an aborted load never leaves a partial program.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 16; i++) r_mem[i] <= 8'h00;
        end else if (w_accept) begin
            r_mem[r_wr_ptr] <= bus.ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state     <= S_REL;
            r_wr_ptr    <= 4'd0;
            r_last      <= 4'd0;
            r_cnt       <= REL_INIT;
            r_sum       <= 8'h00;
            r_from_load <= 1'b0;
            r_done      <= 1'b0;
            r_cpu_clr_n <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_RUN: begin
                    if (bus.ld_start) begin
                        r_state     <= S_LOAD;
                        r_wr_ptr    <= 4'd0;
                        r_last      <= bus.ld_len;
                        r_sum       <= 8'h00;
                        r_cpu_clr_n <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (bus.ld_valid) begin
                        r_sum <= r_sum + bus.ld_data;
                        // Compare before incrementing so ld_len=15 finishes without wrapping.
                        if (r_wr_ptr == r_last) begin
                            r_state     <= S_REL;
                            r_cnt       <= REL_INIT;
                            r_from_load <= 1'b1;
                        end else begin
                            r_wr_ptr <= r_wr_ptr + 4'd1;
                        end
                    end
                end
                S_REL: begin
                    if (r_cnt == 4'd1) begin
                        r_state     <= S_RUN;
                        r_done      <= r_from_load;
                        r_from_load <= 1'b0;
                        r_cpu_clr_n <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state     <= S_REL;
                    r_cnt       <= REL_INIT;
                    r_from_load <= 1'b0;
                    r_cpu_clr_n <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_rom  = (r_state == S_RUN) ? r_mem[bus.addr_rom] : 8'h00;
    assign bus.ld_ready  = (r_state == S_LOAD);
    assign bus.ld_busy   = (r_state != S_RUN);
    assign bus.ld_done   = r_done;
    assign bus.ld_sum    = r_sum;
    assign bus.cpu_clr_n = r_cpu_clr_n;
endmodule

// File: tb/tb_td4_prog_mem.sv
// Directed, table-driven bench for td4_prog_mem: loads from a vector table plus
// hand-written reset and abort sequences, against a bench-side memory image.
module tb_td4_prog_mem;
    logic clk;
    logic clr;
    int   n_cmp;
    int   n_bad;
    logic [7:0] model [16];

    td4_prog_mem_if bus ();

    td4_prog_mem #(.RELEASE_CYCLES(3)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]       len;
        logic [15:0][7:0] b;
        bit               bub;
        bit               noise;
        logic [7:0]       exp_sum;
        int               exp_cyc;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic do_load(input vec_t v, output int cyc, output int clrn_bad, output int rom_bad);
        int k;
        bit ph;
        @(negedge clk);
        bus.ld_start = 1'b1;
        bus.ld_len   = v.len;
        bus.addr_rom = 4'd0;
        @(negedge clk);
        bus.ld_start = 1'b0;
        cyc = 0; k = 0; ph = 1'b0; clrn_bad = 0; rom_bad = 0;
        while (bus.ld_ready === 1'b1 && cyc < 64) begin
            cyc++;
            if (bus.cpu_clr_n !== 1'b0) clrn_bad++;
            if (bus.data_rom !== 8'h00) rom_bad++;
            if (v.bub && ph) begin
                bus.ld_valid = 1'b0;
            end else begin
                bus.ld_valid = 1'b1;
                bus.ld_data  = v.b[k[3:0]];
                k++;
            end
            bus.ld_start = v.noise && ph;
            if (v.noise) bus.ld_len = 4'd0;
            ph = ~ph;
            @(negedge clk);
        end
        bus.ld_valid = 1'b0;
    endtask

    task automatic count_release(input bit noise, output int relc, output int dones,
                                 output int first_done, output int run_clrn, output int bad);
        bit ph;
        relc = 0; dones = 0; bad = 0; ph = 1'b0;
        while (bus.ld_busy === 1'b1 && relc < 40) begin
            relc++;
            if (bus.cpu_clr_n !== 1'b0 || bus.ld_ready !== 1'b0 || bus.data_rom !== 8'h00) bad++;
            if (bus.ld_done === 1'b1) dones++;
            bus.ld_start = noise && ph;
            ph = ~ph;
            @(negedge clk);
        end
        bus.ld_start = 1'b0;
        first_done = int'(bus.ld_done);
        run_clrn   = int'(bus.cpu_clr_n);
        repeat (4) begin
            if (bus.ld_done === 1'b1) dones++;
            @(negedge clk);
        end
    endtask

    task automatic readback(input string tag);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bus.addr_rom = 4'(i);
            #1;
            chk($sformatf("%s rom[%0d]", tag, i), int'(bus.data_rom), int'(model[i]));
        end
    endtask

    initial begin
        int cyc, clrn_bad, rom_bad, relc, dones, first_done, run_clrn, bad;
        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;

        vecs[0] = '{len: 4'd3, b: '0, bub: 1'b0, noise: 1'b0, exp_sum: 8'hF2, exp_cyc: 4};
        vecs[0].b[0] = 8'h20; vecs[0].b[1] = 8'h02; vecs[0].b[2] = 8'h40; vecs[0].b[3] = 8'h90;
        vecs[1] = vecs[0];
        vecs[1].bub = 1'b1;
        vecs[1].exp_cyc = 7;
        vecs[2] = '{len: 4'd15, b: {16{8'hFF}}, bub: 1'b0, noise: 1'b0, exp_sum: 8'hF0, exp_cyc: 16};
        vecs[3] = '{len: 4'd0, b: '0, bub: 1'b0, noise: 1'b0, exp_sum: 8'h5A, exp_cyc: 1};
        vecs[3].b[0] = 8'h5A;
        vecs[4] = '{len: 4'd3, b: '0, bub: 1'b0, noise: 1'b1, exp_sum: 8'hAA, exp_cyc: 4};
        vecs[4].b[0] = 8'h11; vecs[4].b[1] = 8'h22; vecs[4].b[2] = 8'h33; vecs[4].b[3] = 8'h44;

        bus.addr_rom = 4'd0;
        bus.ld_start = 1'b0;
        bus.ld_len   = 4'd0;
        bus.ld_valid = 1'b0;
        bus.ld_data  = 8'h00;
        clr = 1'b1;

        // Power-on reset release.
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        count_release(1'b0, relc, dones, first_done, run_clrn, bad);
        chk("reset release cycles", relc, 3);
        chk("reset release outputs", bad, 0);
        chk("reset cpu_clr_n after", run_clrn, 1);
        chk("reset ld_busy after", int'(bus.ld_busy), 0);
        chk("reset ld_done count", dones, 0);
        chk("reset ld_sum", int'(bus.ld_sum), 0);
        readback("reset");

        for (int v = 0; v < 5; v++) begin
            do_load(vecs[v], cyc, clrn_bad, rom_bad);
            for (int i = 0; i <= int'(vecs[v].len); i++) model[i] = vecs[v].b[i];
            chk($sformatf("v%0d load cycles", v), cyc, vecs[v].exp_cyc);
            chk($sformatf("v%0d cpu_clr_n in load", v), clrn_bad, 0);
            chk($sformatf("v%0d data_rom in load", v), rom_bad, 0);
            count_release(vecs[v].noise, relc, dones, first_done, run_clrn, bad);
            chk($sformatf("v%0d release cycles", v), relc, 3);
            chk($sformatf("v%0d release outputs", v), bad, 0);
            chk($sformatf("v%0d done on first run", v), first_done, 1);
            chk($sformatf("v%0d done pulses", v), dones, 1);
            chk($sformatf("v%0d cpu_clr_n after", v), run_clrn, 1);
            chk($sformatf("v%0d ld_sum", v), int'(bus.ld_sum), int'(vecs[v].exp_sum));
            readback($sformatf("v%0d", v));
            chk($sformatf("v%0d ld_sum held", v), int'(bus.ld_sum), int'(vecs[v].exp_sum));
        end

        // Abort: reset after two of four bytes.
        @(negedge clk);
        bus.ld_start = 1'b1;
        bus.ld_len   = 4'd3;
        @(negedge clk);
        bus.ld_start = 1'b0;
        bus.ld_valid = 1'b1;
        bus.ld_data  = 8'hAA;
        @(negedge clk);
        bus.ld_data  = 8'hBB;
        @(negedge clk);
        bus.ld_valid = 1'b0;
        chk("abort still loading", int'(bus.ld_ready), 1);
        clr = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        count_release(1'b0, relc, dones, first_done, run_clrn, bad);
        chk("abort release cycles", relc, 3);
        chk("abort release outputs", bad, 0);
        chk("abort done pulses", dones, 0);
        chk("abort cpu_clr_n after", run_clrn, 1);
        chk("abort ld_sum", int'(bus.ld_sum), 0);
        readback("abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
